piece_move_sequencer: RTL

- Sequences falling-piece movement on the 4x6 play grid.
- Arbitrates player button requests (up/down/left/right) against the gravity tick, gates each request with the aggregated per-direction move enables, and issues one move at a time to the board datapath over a valid/ack handshake.
- Handles lock-on-landing, new-piece spawn handshake and game-over detection.
- Sits between the button synchronizers, the move-enable aggregation logic and the board/piece register block.

---
 rtl/piece_move_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/piece_move_sequencer.sv
// Falling-piece move sequencer: arbitrates gravity and button requests, issues one move at a
// time to the board over valid/ack, and handles lock, spawn and game-over.
module piece_move_sequencer #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned LOCK_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       up_en,
  input  logic       down_en,
  input  logic       left_en,
  input  logic       right_en,
  output logic       move_valid,
  output logic [1:0] move_dir,
  input  logic       move_ack,
  output logic       spawn_req,
  input  logic       spawn_ack,
  output logic       lock_o,
  output logic       game_over,
  output logic [2:0] state_o
);

  localparam int unsigned CntW  = $clog2(TICK_DIV);
  localparam int unsigned LockW = $clog2(LOCK_TICKS + 1);
  localparam logic [CntW-1:0]  CntMax   = CntW'(TICK_DIV - 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_TICKS - 1);

  localparam logic [1:0] DirUp    = 2'd0;
  localparam logic [1:0] DirDown  = 2'd1;
  localparam logic [1:0] DirLeft  = 2'd2;
  localparam logic [1:0] DirRight = 2'd3;

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StSpawn  = 3'd1,
    StSettle = 3'd2,
    StActive = 3'd3,
    StMove   = 3'd4,
    StLock   = 3'd5,
    StOver   = 3'd6
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  grav_cnt_q, grav_cnt_d;
  logic             grav_pend_q, grav_pend_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       btn_hist_q;
  logic [LockW-1:0] lock_cnt_q;
  logic             move_valid_q, spawn_req_q, lock_q, game_over_q;
  logic [1:0]       move_dir_q;

  logic [3:0] btn_now, en_now, pend_set, pend_clr;
  logic       capture, grav_wrap, grav_clr;
  logic       sel_move, sel_lock, lock_inc;
  logic [1:0] sel_dir;

  assign btn_now = {btn_right, btn_left, btn_down, btn_up};
  assign en_now  = {right_en, left_en, down_en, up_en};

  always_comb begin
    capture   = (state_q == StActive) || (state_q == StMove);
    pend_set  = capture ? (btn_now & ~btn_hist_q) : 4'b0;
    grav_wrap = capture && (grav_cnt_q == CntMax);
    pend_clr  = 4'b0;
    grav_clr  = 1'b0;
    sel_move  = 1'b0;
    sel_lock  = 1'b0;
    lock_inc  = 1'b0;
    sel_dir   = DirDown;
    if (state_q == StActive) begin
      // Priority: gravity > down > left > right > up
      if (grav_pend_q) begin
        if (down_en) sel_move = 1'b1;
        else begin
          grav_clr = 1'b1;
          lock_inc = 1'b1;
        end
      end else if (pend_q[DirDown]) begin
        if (down_en) sel_move = 1'b1;
        else begin
          pend_clr[DirDown] = 1'b1;
          sel_lock          = 1'b1;
        end
      end else if (pend_q[DirLeft]) begin
        sel_dir = DirLeft;
        if (left_en) sel_move = 1'b1;
        else pend_clr[DirLeft] = 1'b1;
      end else if (pend_q[DirRight]) begin
        sel_dir = DirRight;
        if (right_en) sel_move = 1'b1;
        else pend_clr[DirRight] = 1'b1;
      end else if (pend_q[DirUp]) begin
        sel_dir = DirUp;
        if (up_en) sel_move = 1'b1;
        else pend_clr[DirUp] = 1'b1;
      end
    end else if (state_q == StMove && move_ack) begin
      if (move_dir_q == DirDown) begin
        grav_clr          = 1'b1;
        pend_clr[DirDown] = 1'b1;
      end else begin
        pend_clr[move_dir_q] = 1'b1;
      end
    end else if (state_q == StLock) begin
      pend_clr = 4'hf;
      grav_clr = 1'b1;
    end
    // Sets are applied after clears so a same-cycle set survives
    pend_d      = (pend_q & ~pend_clr) | pend_set;
    grav_pend_d = (grav_pend_q & ~grav_clr) | grav_wrap;
    if (!capture || grav_wrap) grav_cnt_d = '0;
    else grav_cnt_d = grav_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      grav_cnt_q   <= '0;
      grav_pend_q  <= 1'b0;
      pend_q       <= 4'b0;
      btn_hist_q   <= 4'b0;
      lock_cnt_q   <= '0;
      move_valid_q <= 1'b0;
      move_dir_q   <= 2'd0;
      spawn_req_q  <= 1'b0;
      lock_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      grav_cnt_q  <= grav_cnt_d;
      grav_pend_q <= grav_pend_d;
      pend_q      <= pend_d;
      btn_hist_q  <= btn_now;
      lock_q      <= 1'b0;
      unique case (state_q)
        StInit: begin
          state_q     <= StSpawn;
          spawn_req_q <= 1'b1;
        end
        StSpawn: begin
          if (spawn_ack) begin
            state_q     <= StSettle;
            spawn_req_q <= 1'b0;
          end
        end
        StSettle: begin
          if (!down_en) begin
            state_q     <= StOver;
            game_over_q <= 1'b1;
          end else begin
            state_q <= StActive;
          end
        end
        StActive: begin
          if (sel_move) begin
            state_q      <= StMove;
            move_dir_q   <= sel_dir;
            move_valid_q <= 1'b1;
          end else if (lock_inc) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
            if (lock_cnt_q == LockLast) begin
              state_q <= StLock;
              lock_q  <= 1'b1;
            end
          end else if (sel_lock) begin
            state_q <= StLock;
            lock_q  <= 1'b1;
          end
        end
        StMove: begin
          if (move_ack) begin
            state_q      <= StActive;
            move_valid_q <= 1'b0;
            if (move_dir_q == DirDown) lock_cnt_q <= '0;
          end
        end
        StLock: begin
          state_q     <= StSpawn;
          spawn_req_q <= 1'b1;
          lock_cnt_q  <= '0;
        end
        StOver: state_q <= StOver;
        default: state_q <= StInit;
      endcase
    end
  end

  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;
  assign spawn_req  = spawn_req_q;
  assign lock_o     = lock_q;
  assign game_over  = game_over_q;
  assign state_o    = state_q;

endmodule
